// File: rtl/lanzones_core_if.sv
// Memory bus bundle for lanzones_core: read request/valid and strobed write.
// master: RRdy/RAddr/RWEn/RWData/RWStrobe out, RVld/RData in; slave mirrors.
interface lanzones_core_if #(
  parameter int MEM_AW = 32
);
  logic              RRdy;
  logic [MEM_AW-1:0] RAddr;
  logic              RVld;
  logic [31:0]       RData;
  logic              RWEn;
  logic [31:0]       RWData;
  logic [3:0]        RWStrobe;

  modport master (
    output RRdy, RAddr, RWEn, RWData, RWStrobe,
    input  RVld, RData
  );

  modport slave (
    input  RRdy, RAddr, RWEn, RWData, RWStrobe,
    output RVld, RData
  );
endinterface

// File: rtl/lanzones_core.sv
// Multi-cycle RV32I core on one shared word-addressed memory port.
// Ports: clk, rstn (async low), LEn start pulse, Halt sticky, mem bus (master).
module lanzones_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_AW   = 32
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           LEn,
  output logic           Halt,
  lanzones_core_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEMRD, S_MEMWR, S_WB, S_HALT
  } state_t;

  state_t            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       ir_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [31:0]       res_q;
  logic [31:0]       npc_q;
  logic [1:0]        ea_lo_q;
  logic [31:0]       rf_q [32];
  logic              rrdy_q;
  logic [MEM_AW-1:0] raddr_q;
  logic              rwen_q;
  logic [31:0]       rwdata_q;
  logic [3:0]        strb_q;
  logic              halt_q;

  assign mem.RRdy     = rrdy_q;
  assign mem.RAddr    = raddr_q;
  assign mem.RWEn     = rwen_q;
  assign mem.RWData   = rwdata_q;
  assign mem.RWStrobe = strb_q;
  assign Halt         = halt_q;

  function automatic logic [MEM_AW-1:0] waddr(
    input logic [31:0] b
  );
    return MEM_AW'(b[31:2]);
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign rd  = ir_q[11:7];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi;
  logic is_op, is_fence, legal, wr_rd;

  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_br    = opc == 7'b1100011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_opi   = opc == 7'b0010011;
  assign is_op    = opc == 7'b0110011;
  assign is_fence = opc == 7'b0001111;

  // SYSTEM (ECALL/EBREAK) and unknown opcodes fall out as illegal
  assign legal = is_lui | is_auipc | is_jal | is_jalr
               | is_br | is_ld | is_st | is_opi
               | is_op | is_fence;

  assign wr_rd = is_lui | is_auipc | is_jal | is_jalr
               | is_ld | is_opi | is_op;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                  ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'h000};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                  ir_q[20], ir_q[30:21], 1'b0};

  logic [31:0] opb, alu, res_d, npc_d, pc4, ea_d;
  logic [31:0] st_data, ld_d;
  logic [3:0]  st_strb;
  logic [4:0]  sh;
  logic        take;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign pc4  = pc_q + 32'd4;
  assign opb  = is_op ? b_q : imm_i;
  assign sh   = opb[4:0];
  assign ea_d = a_q + (is_st ? imm_s : imm_i);

  always_comb begin
    alu = '0;
    unique case (f3)
      3'b000: alu = (is_op && ir_q[30]) ? a_q - opb
                                        : a_q + opb;
      3'b001: alu = a_q << sh;
      3'b010: alu = {31'b0, $signed(a_q) < $signed(opb)};
      3'b011: alu = {31'b0, a_q < opb};
      3'b100: alu = a_q ^ opb;
      3'b101: alu = ir_q[30] ? $unsigned($signed(a_q) >>> sh)
                             : a_q >> sh;
      3'b110: alu = a_q | opb;
      3'b111: alu = a_q & opb;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (f3)
      3'b000:  take = a_q == b_q;
      3'b001:  take = a_q != b_q;
      3'b100:  take = $signed(a_q) <  $signed(b_q);
      3'b101:  take = $signed(a_q) >= $signed(b_q);
      3'b110:  take = a_q <  b_q;
      3'b111:  take = a_q >= b_q;
      default: take = 1'b0;
    endcase
  end

  // Control-flow targets always land word-aligned
  always_comb begin
    res_d = alu;
    npc_d = pc4;
    unique case (1'b1)
      is_lui:   res_d = imm_u;
      is_auipc: res_d = pc_q + imm_u;
      is_jal: begin
        res_d = pc4;
        npc_d = (pc_q + imm_j) & ~32'd3;
      end
      is_jalr: begin
        res_d = pc4;
        npc_d = (a_q + imm_i) & ~32'd3;
      end
      is_br: begin
        if (take) npc_d = (pc_q + imm_b) & ~32'd3;
      end
      default: res_d = alu;
    endcase
  end

  // Store data is replicated so the strobe alone picks the lane
  always_comb begin
    st_data = b_q;
    st_strb = 4'b1111;
    unique case (f3[1:0])
      2'b00: begin
        st_data = {4{b_q[7:0]}};
        st_strb = 4'b0001 << ea_d[1:0];
      end
      2'b01: begin
        st_data = {2{b_q[15:0]}};
        st_strb = ea_d[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = b_q;
        st_strb = 4'b1111;
      end
    endcase
  end

  assign ld_b = mem.RData[8*ea_lo_q +: 8];
  assign ld_h = ea_lo_q[1] ? mem.RData[31:16]
                           : mem.RData[15:0];

  always_comb begin
    ld_d = mem.RData;
    case (f3)
      3'b000:  ld_d = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_d = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_d = {24'b0, ld_b};
      3'b101:  ld_d = {16'b0, ld_h};
      default: ld_d = mem.RData;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      npc_q    <= '0;
      ea_lo_q  <= '0;
      rrdy_q   <= 1'b0;
      raddr_q  <= '0;
      rwen_q   <= 1'b0;
      rwdata_q <= '0;
      strb_q   <= '0;
      halt_q   <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (LEn) begin
            pc_q    <= RESET_PC;
            rrdy_q  <= 1'b1;
            raddr_q <= waddr(RESET_PC);
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem.RVld) begin
            ir_q    <= mem.RData;
            rrdy_q  <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q <= rf_q[rs1];
          b_q <= rf_q[rs2];
          if (!legal) begin
            halt_q  <= 1'b1;
            state_q <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q   <= res_d;
          npc_q   <= npc_d;
          ea_lo_q <= ea_d[1:0];
          unique case (1'b1)
            is_ld: begin
              rrdy_q  <= 1'b1;
              raddr_q <= waddr(ea_d);
              state_q <= S_MEMRD;
            end
            is_st: begin
              rwen_q   <= 1'b1;
              raddr_q  <= waddr(ea_d);
              rwdata_q <= st_data;
              strb_q   <= st_strb;
              state_q  <= S_MEMWR;
            end
            default: state_q <= S_WB;
          endcase
        end
        S_MEMRD: begin
          if (mem.RVld) begin
            res_q   <= ld_d;
            rrdy_q  <= 1'b0;
            state_q <= S_WB;
          end
        end
        S_MEMWR: begin
          rwen_q  <= 1'b0;
          strb_q  <= '0;
          state_q <= S_WB;
        end
        S_WB: begin
          if (wr_rd && rd != 5'd0) rf_q[rd] <= res_q;
          pc_q    <= npc_q;
          rrdy_q  <= 1'b1;
          raddr_q <= waddr(npc_q);
          state_q <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lanzones_core.sv
// Bench for lanzones_core: backdoor RAM responder plus read/write scoreboard.
// Directed RV32I programs with hand-computed fetch, store and halt results.
module tb_lanzones_core;

  logic clk;
  logic rstn;
  logic LEn;
  logic Halt;

  lanzones_core_if #(.MEM_AW(32)) bus ();

  lanzones_core #(
    .RESET_PC(32'h0),
    .MEM_AW(32)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .LEn(LEn),
    .Halt(Halt),
    .mem(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } wr_t;

  logic [31:0] ram [0:1023];
  logic [31:0] exp_rd [$];
  wr_t         exp_wr [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // RAM responder: variable 0..2 cycle read latency
  initial begin : resp
    int wcnt;
    int dly;
    int nreq;
    wcnt = 0; dly = 0; nreq = 0;
    bus.RVld  = 1'b0;
    bus.RData = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (bus.RWEn)
        for (int i = 0; i < 4; i++)
          if (bus.RWStrobe[i])
            ram[bus.RAddr[9:0]][8*i +: 8] = bus.RWData[8*i +: 8];
      if (!rstn) begin
        bus.RVld = 1'b0;
        wcnt = 0;
      end else if (bus.RVld) begin
        bus.RVld  = 1'b0;
        bus.RData = 32'hDEADBEEF;
        wcnt = 0;
      end else if (bus.RRdy) begin
        if (wcnt >= dly) begin
          bus.RData = ram[bus.RAddr[9:0]];
          bus.RVld  = 1'b1;
          nreq++;
          dly = nreq % 3;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: pops expected reads/writes as the DUT issues them
  initial begin : mon
    logic        prr;
    logic [31:0] pad;
    wr_t         w;
    prr = 1'b0;
    pad = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        if (bus.RVld) chk("rrdy_after_rvld", {31'b0, bus.RRdy}, 0);
        if (bus.RRdy && prr) chk("raddr_stable", bus.RAddr, pad);
        if (bus.RRdy && !prr) begin
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexp_read act=%h exp=none", bus.RAddr);
          end else begin
            chk("read_addr", bus.RAddr, exp_rd.pop_front());
          end
        end
        if (bus.RWEn) begin
          chk("wr_rrdy_overlap", {31'b0, bus.RRdy}, 0);
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexp_write act=%h exp=none", bus.RAddr);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", bus.RAddr, w.a);
            chk("wr_strb", {28'b0, bus.RWStrobe}, {28'b0, w.s});
            chk("wr_data", bus.RWData, w.d);
          end
        end
      end
      prr = bus.RRdy;
      pad = bus.RAddr;
    end
  end

  task automatic er(input logic [31:0] a);
    exp_rd.push_back(a);
  endtask

  task automatic ew(input logic [31:0] a,
                    input logic [3:0]  s,
                    input logic [31:0] d);
    wr_t w;
    w.a = a; w.s = s; w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic load(input logic [31:0] p [$]);
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < p.size(); i++) ram[i] = p[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic start();
    @(negedge clk);
    LEn = 1'b1;
    @(negedge clk);
    LEn = 1'b0;
  endtask

  task automatic finish_prog(input string nm);
    int n;
    n = 0;
    while (!Halt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_halt"}, {31'b0, Halt}, 1);
    repeat (10) @(negedge clk);
    chk({nm, "_halt_sticky"}, {31'b0, Halt}, 1);
    chk({nm, "_reads_left"}, exp_rd.size(), 0);
    chk({nm, "_writes_left"}, exp_wr.size(), 0);
  endtask

  task automatic prog1();
    load('{32'h00500093, 32'h00708113,
           32'h40202023, 32'h00000073});
    for (int i = 0; i < 4; i++) er(i);
    ew(32'h100, 4'b1111, 32'h0000000C);
  endtask

  task automatic prog2();
    logic [31:0] rs [$];
    load('{32'h08000093, 32'h401000A3, 32'h40100183,
           32'h40104203, 32'h40302423, 32'h40402623,
           32'h40301923, 32'h41201283, 32'h41205303,
           32'h40502A23, 32'h40602C23, 32'h00000073});
    rs = '{0, 1, 2, 32'h100, 3, 32'h100, 4, 5, 6,
           7, 32'h104, 8, 32'h104, 9, 10, 11};
    foreach (rs[i]) er(rs[i]);
    ew(32'h100, 4'b0010, 32'h80808080);
    ew(32'h102, 4'b1111, 32'hFFFFFF80);
    ew(32'h103, 4'b1111, 32'h00000080);
    ew(32'h104, 4'b1100, 32'hFF80FF80);
    ew(32'h105, 4'b1111, 32'hFFFFFF80);
    ew(32'h106, 4'b1111, 32'h0000FF80);
  endtask

  task automatic prog3();
    logic [31:0] rs [$];
    load('{32'h00000093, 32'h00500113, 32'h00108093,
           32'hFE209EE3, 32'h40102023, 32'h00000073});
    rs = '{0, 1, 2, 3, 2, 3, 2, 3, 2, 3, 2, 3, 4, 5};
    foreach (rs[i]) er(rs[i]);
    ew(32'h100, 4'b1111, 32'h00000005);
  endtask

  task automatic prog4();
    logic [31:0] rs [$];
    load('{32'h800000B7, 32'h4040D113, 32'h401101B3,
           32'h00312233, 32'h008002EF, 32'h06300213,
           32'h00001317, 32'h00D283E7, 32'h40302023,
           32'h40402223, 32'h40602423, 32'h40702623,
           32'h40202823, 32'h00100073});
    rs = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13};
    foreach (rs[i]) er(rs[i]);
    ew(32'h100, 4'b1111, 32'h78000000);
    ew(32'h101, 4'b1111, 32'h00000001);
    ew(32'h102, 4'b1111, 32'h00001018);
    ew(32'h103, 4'b1111, 32'h00000020);
    ew(32'h104, 4'b1111, 32'hF8000000);
  endtask

  initial begin : stim
    int n;
    rstn = 1'b0;
    LEn  = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_quiet", {29'b0, bus.RRdy, bus.RWEn, Halt}, 0);
    end

    prog1(); start(); finish_prog("arith");
    do_reset(); prog2(); start(); finish_prog("bytes");
    do_reset(); prog3(); start(); finish_prog("loop");
    do_reset(); prog4(); start(); finish_prog("alu_jump");

    do_reset(); prog3(); start();
    repeat (12) @(negedge clk);
    n = 0;
    while (!bus.RRdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rrdy_seen", {31'b0, bus.RRdy}, 1);
    #2 rstn = 1'b0;
    #1 chk("mid_async_clear",
           {29'b0, bus.RRdy, bus.RWEn, Halt}, 0);
    exp_rd.delete();
    exp_wr.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mid_idle", {29'b0, bus.RRdy, bus.RWEn, Halt}, 0);
    end
    prog3(); start(); finish_prog("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
